wb_drain: RTL
=============

Name: wb_drain

Overview:
- Read side of the cache write-back buffer: walks the 4-entry buffer in order and transfers each valid evicted line to next-level memory as a beat burst.
- Sits between the write-back buffer read port and the memory write channel.
- Frees each entry by pulsing a valid-clear once memory acknowledges the write.

Parameters:
DEPTH, 4, number of buffer entries (power of 2)
PTR_W, 2, log2(DEPTH)
BEAT_W, 32, memory write data width per beat
BEATS, 8, beats per 256-bit line (256/BEAT_W)
TIMEOUT_CYCLES, 64, mem_done wait limit (used only with WB_TIMEOUT_EN)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low
ent_valid  in  1  valid bit of buffer entry at rd_ptr
ent_addr  in  27  line address of entry at rd_ptr
ent_data  in  256  line data of entry at rd_ptr
rd_ptr  out  PTR_W  buffer entry being examined/drained
ent_clr  out  1  one-cycle pulse: clear valid bit of entry rd_ptr
mem_req  out  1  beat valid toward memory
mem_addr  out  32  byte address of current beat
mem_wdata  out  BEAT_W  current beat data
mem_last  out  1  high with final beat of line
mem_ready  in  1  memory accepts beat this cycle when mem_req=1
mem_done  in  1  memory write-complete acknowledge for the line
busy  out  1  high in any state except IDLE
err  out  1  sticky timeout flag (0 without WB_TIMEOUT_EN)

Behaviour:
- Reset (reset=0, async): state IDLE, rd_ptr=0, beat=0, ent_clr=0, mem_req=0, mem_last=0, mem_addr=0, mem_wdata=0, busy=0, err=0.
- FSM states IDLE, SEND, WAIT, CLR.
- IDLE: if ent_valid=1, latch ent_addr/ent_data into line register, beat=0, go SEND next edge; else stay. First mem_req is 1 cycle after ent_valid is seen.
- SEND: mem_req=1; mem_addr={line_addr, 5'b0} + beat*4; mem_wdata=line_data[beat*BEAT_W +: BEAT_W] (beat 0 = bits 31:0); mem_last=1 when beat==BEATS-1. On mem_ready=1: beat+1; if beat==BEATS-1, go WAIT. Without mem_ready, outputs hold stable.
- WAIT: mem_req=0; on mem_done=1 go CLR.
- CLR: ent_clr=1 for exactly this cycle; rd_ptr increments mod DEPTH (3 -> 0) on exit; go IDLE.
- Minimum per-line occupancy: 1 (IDLE) + BEATS + 1 (WAIT, if mem_done same cycle) + 1 (CLR).
- Drain is strictly in order; an invalid entry at rd_ptr stalls drain (no skipping).
- Data is taken from the latched copy; writer changes to the entry after latch do not affect the burst.
- mem_done outside WAIT is ignored; mem_ready with mem_req=0 is ignored.
- Reset mid-burst: immediate return to reset values; entry is not cleared and is re-drained after reset.
- rd_ptr is a registered output, not combinational.

Optional Feature:
WB_TIMEOUT_EN
- Defined: cycle counter runs in WAIT; if mem_done is not seen within TIMEOUT_CYCLES cycles, set err=1 (sticky until reset), return to SEND with beat=0 and replay the whole line from the latched copy. Counter clears on entry to WAIT.
- Undefined: no counter; WAIT waits indefinitely; err tied 0.

Test Plan:
- Entry 0 valid, addr=27'h0000123, data word i = 32'hA0000000+i; mem_ready=1, mem_done 1 cycle after last beat -> 8 beats, addrs 0x00002460..0x0000247C, mem_last on beat 7 only, ent_clr pulse with rd_ptr=0, then rd_ptr=1.
- mem_ready toggled 1,0,1,0 during SEND -> mem_addr/mem_wdata held during ready=0 cycles, exactly 8 accepted beats, no duplicates.
- Fill all 4 entries, drain all -> rd_ptr 0,1,2,3,0; 4 ent_clr pulses; then IDLE with busy=0 while ent_valid=0.
- ent_data changed at beat 3 -> beats 3..7 still carry latched data.
- reset driven low at beat 5 -> mem_req=0, rd_ptr=0 asynchronously, no ent_clr; after release the same line restarts from beat 0.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES=64, mem_done withheld -> err=1 after 64 WAIT cycles, burst replayed from beat 0; mem_done on replay -> ent_clr pulses, err stays 1.

Source files
------------

// File: rtl/wb_drain.sv
// Write-back buffer drain: walks the buffer in order and sends each valid line to memory as a beat burst.
// Optional WB_TIMEOUT_EN: bounded mem_done wait with sticky err and replay of the latched line.
module wb_drain #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned PTR_W          = 2,
  parameter int unsigned BEAT_W         = 32,
  parameter int unsigned BEATS          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ent_valid,
  input  logic [26:0]       ent_addr,
  input  logic [255:0]      ent_data,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic              ent_clr,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  output logic              mem_last,
  input  logic              mem_ready,
  input  logic              mem_done,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  if (DEPTH != (1 << PTR_W) || BEAT_W * BEATS != 256 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("wb_drain: inconsistent parameters");
  end

  typedef enum logic [1:0] {IDLE, SEND, WAIT, CLR} state_t;

  state_t           state;
  logic [CNT_W-1:0] beat;
  logic [CNT_W-1:0] nxt_beat;
  logic [26:0]      line_addr;
  logic [255:0]     line_data;

  assign nxt_beat = beat + 1'b1;

  function automatic logic [31:0] beat_addr(input logic [26:0] a, input logic [CNT_W-1:0] b);
    return {a, 5'b0} + (32'(b) << 2);
  endfunction

  function automatic logic [BEAT_W-1:0] beat_data(input logic [255:0] d, input logic [CNT_W-1:0] b);
    return d[32'(b) * BEAT_W +: BEAT_W];
  endfunction

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      beat      <= '0;
      ent_clr   <= 1'b0;
      mem_req   <= 1'b0;
      mem_last  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      line_addr <= '0;
      line_data <= '0;
`ifdef WB_TIMEOUT_EN
      tmo_cnt   <= '0;
      err       <= 1'b0;
`endif
    end else begin
      ent_clr <= 1'b0;
      case (state)
        IDLE: begin
          // Beat 0 outputs come straight from the entry since the line register loads on this same edge.
          if (ent_valid) begin
            line_addr <= ent_addr;
            line_data <= ent_data;
            beat      <= '0;
            mem_req   <= 1'b1;
            mem_addr  <= beat_addr(ent_addr, '0);
            mem_wdata <= beat_data(ent_data, '0);
            mem_last  <= (LAST_BEAT == '0);
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (mem_ready) begin
            beat <= nxt_beat;
            if (beat == LAST_BEAT) begin
              mem_req  <= 1'b0;
              mem_last <= 1'b0;
              state    <= WAIT;
`ifdef WB_TIMEOUT_EN
              tmo_cnt  <= '0;
`endif
            end else begin
              mem_addr  <= beat_addr(line_addr, nxt_beat);
              mem_wdata <= beat_data(line_data, nxt_beat);
              mem_last  <= (nxt_beat == LAST_BEAT);
            end
          end
        end
        WAIT: begin
          if (mem_done) begin
            ent_clr <= 1'b1;
            state   <= CLR;
          end
`ifdef WB_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            err       <= 1'b1;
            beat      <= '0;
            mem_req   <= 1'b1;
            mem_addr  <= beat_addr(line_addr, '0);
            mem_wdata <= beat_data(line_data, '0);
            mem_last  <= (LAST_BEAT == '0);
            state     <= SEND;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        CLR: begin
          rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
